sound_sequencer: RTL and testbench

Request sequencer that sits directly upstream of the codec driver. It accepts sound requests, each a sample select plus a duration in milliseconds, from game/control logic through a valid/ready handshake and buffers them in a small FIFO. It plays them back to back by driving the driver's enable, play and sample-select inputs. Every playback is framed by a low-to-high edge on `sound_in`, so the driver restarts its sample ROM address at the start of each sound.

---
 rtl/sound_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_sound_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sound_sequencer.sv
// Queues {sample, duration} sound requests and plays them back to back into the codec driver.
// Each sound starts with a fresh rising edge on sound_in, and a fixed silent gap separates consecutive sounds.
module sound_sequencer #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int TICK_HZ     = 1000,
    parameter int FIFO_DEPTH  = 4,
    parameter int DUR_WIDTH   = 12,
    parameter int GAP_TICKS   = 20
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_sample,
    input  logic [DUR_WIDTH-1:0]          req_duration,
    input  logic                          enable,
    input  logic                          abort,
    output logic                          sound_en,
    output logic                          sound_in,
    output logic                          sound_sample,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   queue_count
);
    localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int GW  = $clog2(GAP_TICKS + 1);
    localparam int CW  = (DUR_WIDTH > GW) ? DUR_WIDTH : GW;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_TICKS);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SKIP = 2'd1,
        ST_PLAY = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    typedef struct packed {
        logic                 sample;
        logic [DUR_WIDTH-1:0] dur;
    } entry_t;

    state_t        state_q, state_d;
    entry_t        fifo_mem_q [FIFO_DEPTH];
    entry_t        fifo_mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sample_q, sample_d;
    logic          sound_in_q, sound_in_d;
    logic          sound_en_q, sound_en_d;
    logic          push_s, pop_s, dispatch_s, tick_s, fifo_empty_s;
    entry_t        head_s;

    // A full FIFO refuses a push even if it pops in the same cycle
    assign req_ready    = (count_q != FULL_COUNT);
    assign push_s       = req_valid && req_ready && !abort;
    assign tick_s       = (presc_q == PRESC_LAST);
    assign fifo_empty_s = (count_q == '0);
    assign head_s       = fifo_mem_q[rd_ptr_q];

    // Sequencing FSM: tick countdown, dispatch of the FIFO head, output next values
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sample_d   = sample_q;
        pop_s      = 1'b0;
        dispatch_s = 1'b0;
        sound_in_d = 1'b0;
        sound_en_d = 1'b0;
        if (tick_s) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PW'(1);
        end
        case (state_q)
            ST_IDLE, ST_SKIP: dispatch_s = 1'b1;
            ST_PLAY: begin
                if (tick_s && (cnt_q <= CW'(1))) begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_LOAD;
                    presc_d = '0;
                end else if (tick_s) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_GAP: begin
                if (tick_s && (cnt_q <= CW'(1))) begin
                    dispatch_s = 1'b1;
                end else if (tick_s) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Zero-duration requests pass through SKIP without touching the outputs
        if (dispatch_s && !fifo_empty_s) begin
            pop_s = 1'b1;
            if (head_s.dur == '0) begin
                state_d = ST_SKIP;
            end else begin
                state_d  = ST_PLAY;
                cnt_d    = CW'(head_s.dur);
                sample_d = head_s.sample;
                presc_d  = '0;
            end
        end else if (dispatch_s) begin
            state_d = ST_IDLE;
        end else begin
            pop_s = 1'b0;
        end
        if (abort) begin
            state_d    = ST_IDLE;
            pop_s      = 1'b0;
            sound_en_d = 1'b0;
        end else begin
            sound_en_d = enable;
        end
        sound_in_d = (state_d == ST_PLAY);
    end

    // Request FIFO storage, pointers and occupancy
    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (abort) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_s) begin
                fifo_mem_d[wr_ptr_q] = '{sample: req_sample, dur: req_duration};
                wr_ptr_d             = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + (AW + 1)'(1);
                2'b01:   count_d = count_q - (AW + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            fifo_mem_q <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            presc_q    <= '0;
            cnt_q      <= '0;
            sample_q   <= 1'b0;
            sound_in_q <= 1'b0;
            sound_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fifo_mem_q <= fifo_mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            presc_q    <= presc_d;
            cnt_q      <= cnt_d;
            sample_q   <= sample_d;
            sound_in_q <= sound_in_d;
            sound_en_q <= sound_en_d;
        end
    end

    assign sound_in     = sound_in_q;
    assign sound_en     = sound_en_q;
    assign sound_sample = sample_q;
    assign queue_count  = count_q;
    assign busy         = (state_q != ST_IDLE) || !fifo_empty_s;

endmodule

// File: tb/tb_sound_sequencer.sv
// Scoreboard bench for sound_sequencer: accepted requests are queued as expected pulses,
// and a monitor checks every sound_in pulse against them as it appears.
module tb_sound_sequencer;
    localparam int DIV   = 10;
    localparam int GAP   = 2;
    localparam int DEPTH = 4;
    localparam int DW    = 12;

    logic          clk          = 1'b0;
    logic          rst_n        = 1'b0;
    logic          req_valid    = 1'b0;
    logic          req_sample   = 1'b0;
    logic [DW-1:0] req_duration = '0;
    logic          enable       = 1'b1;
    logic          abort        = 1'b0;
    logic          req_ready, sound_en, sound_in, sound_sample, busy;
    logic [2:0]    queue_count;

    sound_sequencer #(
        .CLK_FREQ_HZ(1000), .TICK_HZ(100), .FIFO_DEPTH(DEPTH),
        .DUR_WIDTH(DW), .GAP_TICKS(GAP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_sample(req_sample), .req_duration(req_duration), .enable(enable),
        .abort(abort), .sound_en(sound_en), .sound_in(sound_in),
        .sound_sample(sound_sample), .busy(busy), .queue_count(queue_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic sample;
        int   dur;
    } req_t;

    req_t pending[$];
    req_t mon_r;
    int   n_checks    = 0;
    int   n_fail      = 0;
    int   n_pulses    = 0;
    int   last_gap    = 0;
    int   low_count   = 0;
    int   width       = 0;
    int   exp_width   = 0;
    logic exp_sample  = 1'b0;
    logic prev_in     = 1'b0;
    logic cur_aborted = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Pulse monitor: pops the next non-zero request at each rising edge of sound_in
    always @(negedge clk) begin
        if (sound_in === 1'b1 && prev_in !== 1'b1) begin
            while (pending.size() > 0 && pending[0].dur == 0) pending.delete(0);
            check("pulse_expected", 32'(pending.size() > 0), 32'd1);
            if (pending.size() > 0) begin
                mon_r = pending.pop_front();
                exp_width  = mon_r.dur * DIV;
                exp_sample = mon_r.sample;
                check("pulse_sample", 32'(sound_sample), 32'(exp_sample));
            end else begin
                exp_width = 0;
            end
            last_gap    = low_count;
            width       = 1;
            n_pulses++;
            cur_aborted = 1'b0;
        end else if (sound_in === 1'b1) begin
            width++;
        end else if (prev_in === 1'b1) begin
            if (!cur_aborted) check("pulse_width", 32'(width), 32'(exp_width));
            low_count = 1;
        end else begin
            low_count++;
        end
        prev_in = sound_in;
    end

    task automatic send(input logic s, input int d, output int waited);
        waited       = 0;
        req_valid    = 1'b1;
        req_sample   = s;
        req_duration = DW'(d);
        while (req_ready !== 1'b1 && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        check("send_accepted", 32'(req_ready), 32'd1);
        if (req_ready === 1'b1) pending.push_back('{sample: s, dur: d});
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy === 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(busy), 32'd0);
        while (pending.size() > 0 && pending[0].dur == 0) pending.delete(0);
        check({name, "_drained"}, 32'(pending.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sound_en"}, 32'(sound_en), 32'd0);
        check({tag, "_sound_in"}, 32'(sound_in), 32'd0);
        check({tag, "_sound_sample"}, 32'(sound_sample), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_queue_count"}, 32'(queue_count), 32'd0);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        int   w, n, p0, nz, nreq, d;
        logic s;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("en_after_reset", 32'(sound_en), 32'd1);

        // Single request: pop one edge after acceptance, 30 high, 20 low
        send(1'b1, 3, w);
        check("single_count_k", 32'(queue_count), 32'd1);
        check("single_in_k", 32'(sound_in), 32'd0);
        @(negedge clk);
        check("single_in_k1", 32'(sound_in), 32'd1);
        check("single_sample", 32'(sound_sample), 32'd1);
        check("single_count_k1", 32'(queue_count), 32'd0);
        n = 0;
        while (sound_in === 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("single_high", 32'(n), 32'(3 * DIV));
        n = 0;
        while (busy === 1'b1 && n < 500) begin
            n++;
            @(negedge clk);
        end
        check("single_gap_to_idle", 32'(n), 32'(GAP * DIV));
        wait_idle("single_idle");

        // Back to back
        p0 = n_pulses;
        send(1'b0, 2, w);
        send(1'b1, 1, w);
        wait_idle("b2b_idle");
        check("b2b_pulses", 32'(n_pulses - p0), 32'd2);
        check("b2b_gap", 32'(last_gap), 32'(GAP * DIV));

        // Full FIFO while the first request plays
        p0 = n_pulses;
        send(1'b0, 3, w);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            s = 1'($urandom_range(0, 1));
            send(s, int'($urandom_range(1, 3)), w);
        end
        check("full_count", 32'(queue_count), 32'd4);
        check("full_ready", 32'(req_ready), 32'd0);
        send(1'b1, 2, w);
        check("full_fifth_held", 32'(w > 0), 32'd1);
        wait_idle("full_idle");
        check("full_pulses", 32'(n_pulses - p0), 32'd6);

        // Zero-duration request between two sounds
        p0 = n_pulses;
        send(1'b0, 1, w);
        send(1'b1, 0, w);
        send(1'b0, 1, w);
        wait_idle("zero_idle");
        check("zero_pulses", 32'(n_pulses - p0), 32'd2);
        check("zero_gap", 32'(last_gap), 32'(GAP * DIV + 1));

        // Abort five cycles into PLAY with two queued and a simultaneous push
        p0 = n_pulses;
        send(1'b0, 5, w);
        send(1'b1, 2, w);
        send(1'b0, 3, w);
        repeat (3) @(negedge clk);
        check("abort_queued", 32'(queue_count), 32'd2);
        check("abort_playing", 32'(sound_in), 32'd1);
        abort        = 1'b1;
        req_valid    = 1'b1;
        req_sample   = 1'b1;
        req_duration = DW'(7);
        pending.delete();
        cur_aborted  = 1'b1;
        @(negedge clk);
        abort     = 1'b0;
        req_valid = 1'b0;
        check("abort_sound_in", 32'(sound_in), 32'd0);
        check("abort_count", 32'(queue_count), 32'd0);
        check("abort_sound_en", 32'(sound_en), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("abort_en_back", 32'(sound_en), 32'd1);
        repeat (40) @(negedge clk);
        check("abort_no_new_pulse", 32'(n_pulses - p0), 32'd1);
        check("abort_push_dropped", 32'(queue_count), 32'd0);

        // Abort while idle only touches sound_en
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("idle_abort_en", 32'(sound_en), 32'd0);
        check("idle_abort_busy", 32'(busy), 32'd0);
        check("idle_abort_ready", 32'(req_ready), 32'd1);

        // Mute toggling during playback
        p0 = n_pulses;
        send(1'b1, 4, w);
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            s      = 1'($urandom_range(0, 1));
            enable = s;
            @(negedge clk);
            check("mute_follow", 32'(sound_en), 32'(s));
        end
        check("mute_still_playing", 32'(sound_in), 32'd1);
        enable = 1'b1;
        wait_idle("mute_idle");
        check("mute_pulses", 32'(n_pulses - p0), 32'd1);

        // Asynchronous reset mid-PLAY
        send(1'b1, 5, w);
        send(1'b0, 2, w);
        repeat (4) @(negedge clk);
        check("prereset_playing", 32'(sound_in), 32'd1);
        check("prereset_count", 32'(queue_count), 32'd1);
        pending.delete();
        cur_aborted = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Randomised batches
        for (int b = 0; b < 5; b++) begin
            p0   = n_pulses;
            nz   = 0;
            nreq = int'($urandom_range(1, 6));
            for (int i = 0; i < nreq; i++) begin
                s = 1'($urandom_range(0, 1));
                d = int'($urandom_range(0, 3));
                if (d != 0) nz++;
                send(s, d, w);
            end
            wait_idle("rand_idle");
            check("rand_pulses", 32'(n_pulses - p0), 32'(nz));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
